siso_loopback_seq: RTL
======================

Name: siso_loopback_seq

Overview:
- Sequencer for the team's serial-in/serial-out shift chain (siso_nbit style, depth DEPTH, one bit per clock, no enable).
- Accepts a parallel word over a start/ready handshake, drives it LSB-first into the chain's d_in, and reassembles the word from the chain's q_out after the chain latency.
- Flags whether the returned word matches the sent word.
- Used as a self-test and transfer controller around the chain, sharing the chain's clock and reset.

Parameters:
- W, 4, word width in bits (W >= 1).
- DEPTH, 4, flop depth of the attached SISO chain (DEPTH >= 1).

Ports:
- clk  input  1  rising-edge clock, shared with the chain.
- reset_al_in  input  1  asynchronous active-low reset, shared with the chain.
- start_in  input  1  request to send tx_data_in; accepted only when ready_out=1.
- tx_data_in  input  W  word to send; sampled on the accepting edge.
- ready_out  output  1  high in IDLE only.
- ser_out  output  1  registered; connects to the chain's d_in.
- ser_in  input  1  connects to the chain's q_out.
- busy_out  output  1  high in BUSY.
- done_out  output  1  one-cycle pulse in DONE.
- rx_data_out  output  W  reassembled word; valid from DONE, held until the next DONE.
- match_out  output  1  rx_data_out == captured tx word; valid from DONE, held until the next DONE.

Behaviour:
- Reset (reset_al_in=0, asynchronous):
  - State goes to IDLE and the counter to 0.
  - ready_out=1; ser_out, busy_out, done_out, match_out = 0; rx_data_out=0; internal tx register = 0.
- Reset asserted mid-transaction aborts immediately. No done_out is produced, and rx_data_out/match_out clear to 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - ready_out=1 and ser_out=0.
  - On an edge with start_in=1: latch tx_data_in into tx_reg, clear the rx shift register, set cnt=0, go to BUSY.
  - start_in=0 leaves the block in IDLE.
- BUSY:
  - Counter cnt runs 0 .. W+DEPTH-1, one step per clock.
  - During cycle cnt < W, ser_out = tx_reg[cnt]. For cnt >= W, ser_out=0 (flush).
  - Because ser_out is registered, the value shown during cycle cnt is set at the edge that begins that cycle.
  - At the end of each cycle with cnt >= DEPTH, store ser_in into rx[cnt-DEPTH].
  - A bit presented during cycle k therefore appears on ser_in during cycle k+DEPTH.
  - At the end of cycle cnt = W+DEPTH-1, go to DONE.
  - BUSY lasts exactly W+DEPTH cycles.
- DONE:
  - Lasts one cycle with done_out=1.
  - rx_data_out and match_out update on the edge entering DONE.
  - Next state is IDLE. ready_out=0 during DONE, so back-to-back starts have a 1-cycle gap.
- Handshake and timing:
  - start_in is ignored while in BUSY or DONE; there is no queuing.
  - Latency from the accepting edge to the done_out pulse is W+DEPTH+1 edges.
- Width rules:
  - cnt width is clog2(W+DEPTH+1).
  - Comparison covers all W bits; no arithmetic on data.
- Restrictions:
  - ser_in must not be sampled outside BUSY.
  - The chain must be reset together with this block so that flush zeros are deterministic.

Optional Feature:
- Macro: SISO_LOOPBACK_SEQ_PARITY_EN.
- When defined:
  - An even-parity bit (XOR of tx_reg) is sent as bit index W. ser_out = parity while cnt = W.
  - BUSY lasts W+1+DEPTH cycles.
  - The returned parity bit is captured at cnt = W+DEPTH.
  - Extra output parity_err_out (1 bit) is set in DONE when the returned parity ≠ XOR of rx_data_out, and held like match_out.
  - match_out additionally requires parity_err_out=0.
  - parity_err_out resets to 0.
- When undefined: the port is absent and timing is as specified in Behaviour.

Test Plan (W=4, DEPTH=4, real siso_nbit chain attached unless noted):
- Reset check: hold reset_al_in=0 for 5 ns, then release -> ready_out=1, busy_out=0, done_out=0, rx_data_out=0, match_out=0, ser_out=0.
- Basic transfer: start_in=1 for one cycle with tx_data_in=4'b1011 -> ser_out sequence 1,1,0,1,0,0,0,0 over 8 BUSY cycles; done_out pulses on the 9th edge after acceptance; rx_data_out=4'b1011, match_out=1.
- Busy ignore: hold start_in=1 with tx_data_in=4'hF throughout the transfer of 4'h6 -> first done gives rx=4'h6; the next acceptance occurs only after DONE, giving rx=4'hF, match=1.
- Fault: replace the chain with ser_in tied to 0 and send 4'h9 -> rx_data_out=4'h0, match_out=0.
- Reset mid-operation: assert reset_al_in at cnt=3 -> immediate IDLE, no done_out, rx_data_out=0; after release, sending 4'h5 completes with match_out=1.
- Parity (macro defined): send 4'b0111 -> parity bit 1 sent at cnt=4, done on the 10th edge, parity_err_out=0; with ser_in forced to 0 during cnt=8, parity_err_out=1 and match_out=0.

Source files
------------

// File: rtl/siso_loopback_seq.sv
// siso_loopback_seq: drives a parallel word LSB-first into an external
// serial-in/serial-out chain of depth DEPTH, reassembles the word from the
// chain output after the chain latency, and reports whether it came back intact.
// Optional feature macro: SISO_LOOPBACK_SEQ_PARITY_EN appends an even-parity
// bit to the frame and adds parity_err_out.
module siso_loopback_seq #(
   parameter int W     = 4,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_al_in,
   input  logic         start_in,
   input  logic [W-1:0] tx_data_in,
   output logic         ready_out,
   output logic         ser_out,
   input  logic         ser_in,
   output logic         busy_out,
   output logic         done_out,
   output logic [W-1:0] rx_data_out,
`ifdef SISO_LOOPBACK_SEQ_PARITY_EN
   output logic         parity_err_out,
`endif
   output logic         match_out
);

`ifdef SISO_LOOPBACK_SEQ_PARITY_EN
   localparam int NB = W + 1;   // data bits plus parity bit
`else
   localparam int NB = W;
`endif
   localparam int CNT_W = $clog2(NB + DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB + DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ser_q, ser_d;
   logic [W-1:0]     tx_q, tx_d;
   logic [NB-1:0]    rx_q, rx_d;
   logic [W-1:0]     rx_data_q, rx_data_d;
   logic             match_q, match_d;
   logic [NB-1:0]    frame;
   logic [NB-1:0]    rx_cap;
`ifdef SISO_LOOPBACK_SEQ_PARITY_EN
   logic             perr_q, perr_d;
   logic             perr_now;
`endif

   // Outgoing frame: data word, optionally followed by its even parity.
`ifdef SISO_LOOPBACK_SEQ_PARITY_EN
   assign frame = {^tx_q, tx_q};
`else
   assign frame = tx_q;
`endif

   // Bit gi of the frame returns on ser_in during BUSY cycle gi+DEPTH.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_rx_cap
         assign rx_cap[gi] = (cnt_q == CNT_W'(gi + DEPTH)) ? ser_in : rx_q[gi];
      end
   endgenerate

`ifdef SISO_LOOPBACK_SEQ_PARITY_EN
   assign perr_now = rx_cap[W] ^ (^rx_cap[W-1:0]);
`endif

   // Next-state, counter, serializer and result logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ser_d     = 1'b0;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rx_data_d = rx_data_q;
      match_d   = match_q;
`ifdef SISO_LOOPBACK_SEQ_PARITY_EN
      perr_d    = perr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               tx_d    = tx_data_in;
               rx_d    = '0;
               cnt_d   = '0;
               ser_d   = tx_data_in[0];   // bit 0 is shown during cnt=0
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            rx_d = rx_cap;
            if (cnt_q == CNT_LAST) begin
               state_d   = S_DONE;
               rx_data_d = rx_cap[W-1:0];
`ifdef SISO_LOOPBACK_SEQ_PARITY_EN
               perr_d    = perr_now;
               match_d   = (rx_cap[W-1:0] == tx_q) && !perr_now;
`else
               match_d   = (rx_cap[W-1:0] == tx_q);
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               // Present the bit for the upcoming cycle; beyond the frame, flush zeros.
               for (int i = 1; i < NB; i++) begin
                  if (cnt_q == CNT_W'(i - 1)) ser_d = frame[i];
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_al_in) begin
      if (!reset_al_in) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ser_q     <= 1'b0;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         match_q   <= 1'b0;
`ifdef SISO_LOOPBACK_SEQ_PARITY_EN
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ser_q     <= ser_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rx_data_q <= rx_data_d;
         match_q   <= match_d;
`ifdef SISO_LOOPBACK_SEQ_PARITY_EN
         perr_q    <= perr_d;
`endif
      end
   end

   assign ready_out   = (state_q == S_IDLE);
   assign busy_out    = (state_q == S_BUSY);
   assign done_out    = (state_q == S_DONE);
   assign ser_out     = ser_q;
   assign rx_data_out = rx_data_q;
   assign match_out   = match_q;
`ifdef SISO_LOOPBACK_SEQ_PARITY_EN
   assign parity_err_out = perr_q;
`endif

endmodule
